// File: rtl/alu_pkg.sv
// Opcode constants and controller state encoding shared by the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU; master issues requests, slave computes.
interface alu_mc_if #(parameter int N = 8);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         overflow;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         div_by_zero;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, result_hi,
               overflow, carry, zero, negative, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, result_hi,
               overflow, carry, zero, negative, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// done/lo/hi are the combinational outcome of the step being taken this cycle.
module alu_muldiv_iter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op,      // 0: multiply, 1: divide
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi
);
    localparam int CW = $clog2(N);

    logic          busy;
    logic          op_q;
    logic [CW-1:0] cnt;
    logic [N-1:0]  r_hi, r_lo, opnd;
    logic [N:0]    add_s, shl, trial;
    logic [N-1:0]  nx_hi, nx_lo;

    // Divide: remainder stays below the divisor, so bit N of trial is the borrow.
    always_comb begin
        add_s = {1'b0, r_hi} + (r_lo[0] ? {1'b0, opnd} : '0);
        shl   = {r_hi, r_lo[N-1]};
        trial = shl - {1'b0, opnd};
        if (op_q) begin
            nx_hi = trial[N] ? shl[N-1:0] : trial[N-1:0];
            nx_lo = {r_lo[N-2:0], ~trial[N]};
        end else begin
            nx_hi = add_s[N:1];
            nx_lo = {add_s[0], r_lo[N-1:1]};
        end
    end

    assign done = busy && (cnt == CW'(N - 1));
    assign lo   = nx_lo;
    assign hi   = nx_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            op_q <= 1'b0;
            cnt  <= '0;
            r_hi <= '0;
            r_lo <= '0;
            opnd <= '0;
        end else if (start) begin
            busy <= 1'b1;
            op_q <= op;
            cnt  <= '0;
            r_hi <= '0;
            r_lo <= op ? a : b;
            opnd <= op ? b : a;
        end else if (busy) begin
            r_hi <= nx_hi;
            r_lo <= nx_lo;
            cnt  <= cnt + CW'(1);
            if (done) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL/DIV, valid/ready on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);
    localparam int SW = $clog2(N);

    state_e         state;
    logic           accept, b_zero, iter_op, mul_q;
    logic [N:0]     sum, diff;
    logic [SW-1:0]  sh;
    logic [N-1:0]   c_res, c_hi;
    logic           c_ovf, c_cy, c_dbz;
    logic           it_done;
    logic [N-1:0]   it_lo, it_hi;

    assign bus.in_ready = (state == IDLE);
    assign accept  = bus.in_valid && bus.in_ready;
    assign b_zero  = (bus.b == '0);
    assign iter_op = (bus.sel == OP_MUL) || (bus.sel == OP_DIV && !b_zero);
    assign sh      = bus.b[SW-1:0];
    assign sum     = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff    = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        c_res = '0;
        c_hi  = '0;
        c_ovf = 1'b0;
        c_cy  = 1'b0;
        c_dbz = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                c_res = sum[N-1:0];
                c_cy  = sum[N];
                c_ovf = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                c_res = diff[N-1:0];
                c_cy  = diff[N];
                c_ovf = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
            end
            OP_DIV: begin   // only taken on this path when b == 0
                c_res = '1;
                c_hi  = bus.a;
                c_dbz = 1'b1;
            end
            OP_AND:  c_res = bus.a & bus.b;
            OP_OR:   c_res = bus.a | bus.b;
            OP_NAND: c_res = ~(bus.a & bus.b);
            OP_NOR:  c_res = ~(bus.a | bus.b);
            OP_XOR:  c_res = bus.a ^ bus.b;
            OP_XNOR: c_res = ~(bus.a ^ bus.b);
            OP_NOT:  c_res = ~bus.a;
            OP_SHL:  c_res = bus.a << sh;
            OP_SHR:  c_res = bus.a >> sh;
            OP_SRA:  c_res = $signed(bus.a) >>> sh;
            default: ;
        endcase
    end

    alu_muldiv_iter #(.N(N)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && iter_op),
        .op    (bus.sel == OP_DIV),
        .a     (bus.a),
        .b     (bus.b),
        .done  (it_done),
        .lo    (it_lo),
        .hi    (it_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mul_q           <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.result      <= '0;
            bus.result_hi   <= '0;
            bus.overflow    <= 1'b0;
            bus.carry       <= 1'b0;
            bus.zero        <= 1'b0;
            bus.negative    <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mul_q <= (bus.sel == OP_MUL);
                    if (iter_op) begin
                        state <= BUSY;
                    end else begin
                        state           <= DONE;
                        bus.out_valid   <= 1'b1;
                        bus.result      <= c_res;
                        bus.result_hi   <= c_hi;
                        bus.overflow    <= c_ovf;
                        bus.carry       <= c_cy;
                        bus.zero        <= (c_res == '0);
                        bus.negative    <= c_res[N-1];
                        bus.div_by_zero <= c_dbz;
                    end
                end
                BUSY: if (it_done) begin
                    state           <= DONE;
                    bus.out_valid   <= 1'b1;
                    bus.result      <= it_lo;
                    bus.result_hi   <= it_hi;
                    bus.overflow    <= mul_q && (it_hi != '0);
                    bus.carry       <= 1'b0;
                    bus.zero        <= (it_lo == '0);
                    bus.negative    <= it_lo[N-1];
                    bus.div_by_zero <= 1'b0;
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
